// File: rtl/serial_tx.sv
// -----------------------------------------------------------------------------
// serial_tx
//
// Purpose:
//   Serial transmitter. Accepts one parallel word over a valid/ready handshake
//   and shifts it out on a single line as
//     start (0) | DATA_W data bits, LSB first | [even parity] | STOP_BITS stop (1)
//   Every bit is held for CLK_DIV clocks. The line idles high and is driven
//   straight from a flop, so it cannot glitch.
//
// Parameters:
//   CLK_DIV   clocks per serial bit, 2..255
//   DATA_W    data bits per frame, 5..8
//   PARITY_EN 1 = append an even-parity bit after the data bits
//   STOP_BITS 1 or 2
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   tx_data    in   [DATA_W] word to send, sampled only on the handshake edge
//   tx_valid   in   tx_data is valid
//   tx_ready   out  block can take a word (state == IDLE)
//   sdata_out  out  serial line, registered, idles high
//   tx_done    out  one-cycle pulse in the first IDLE cycle after the last stop bit
//   state      out  [2] FSM state: IDLE=0, START=1, DATA=2, STOP=3
//
// Timing:
//   A word accepted at edge k re-enters IDLE at edge k+F, where
//   F = (1 + DATA_W + PARITY_EN + STOP_BITS) * CLK_DIV. The next word can be
//   accepted at edge k+F+1. The line therefore stays high for one extra clock
//   between back-to-back frames.
// -----------------------------------------------------------------------------
module serial_tx #(
    parameter int CLK_DIV   = 16,
    parameter int DATA_W    = 8,
    parameter int PARITY_EN = 0,
    parameter int STOP_BITS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              sdata_out,
    output logic              tx_done,
    output logic [1:0]        state
);

    // FSM encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    // Baud counter runs 0..CLK_DIV-1. A bit ends when the counter is at CLK_DIV-1.
    localparam int                BAUD_W    = $clog2(CLK_DIV);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
    localparam logic [BAUD_W-1:0] BAUD_ZERO = BAUD_W'(0);
    localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);

    // The bit counter indexes data bits in DATA. When parity is enabled, the
    // value DATA_W selects the parity slot. In STOP it indexes stop bits.
    localparam logic [3:0] BIT_ZERO  = 4'd0;
    localparam logic [3:0] BIT_ONE   = 4'd1;
    localparam logic [3:0] DATA_LAST = 4'(DATA_W - 1);
    localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic       PAR_ON    = (PARITY_EN != 0);

    // Even parity: the XOR of all data bits, so that ones(data) + parity is even.
    function automatic logic even_parity(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction

    logic [1:0]        state_q,  state_d;
    logic [BAUD_W-1:0] baud_q,   baud_d;
    logic [3:0]        bit_q,    bit_d;
    logic [DATA_W-1:0] shift_q,  shift_d;
    logic              parity_q, parity_d;
    logic              sdata_q,  sdata_d;
    logic              done_q,   done_d;
    logic              bit_end_s;

    assign bit_end_s = (baud_q == BAUD_LAST);

    // Next-state and next-output decode for the frame sequencer
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        sdata_d  = sdata_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                baud_d  = BAUD_ZERO;
                bit_d   = BIT_ZERO;
                sdata_d = 1'b1;
                if (tx_valid) begin
                    // Handshake: latch the word and its parity now, because
                    // tx_data is ignored for the rest of the frame.
                    state_d  = ST_START;
                    shift_d  = tx_data;
                    parity_d = even_parity(tx_data);
                    sdata_d  = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_START: begin
                if (bit_end_s) begin
                    baud_d  = BAUD_ZERO;
                    bit_d   = BIT_ZERO;
                    state_d = ST_DATA;
                    sdata_d = shift_q[0];
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end

            ST_DATA: begin
                if (bit_end_s) begin
                    baud_d  = BAUD_ZERO;
                    shift_d = {1'b0, shift_q[DATA_W-1:1]};
                    if (bit_q < DATA_LAST) begin
                        // shift_q[1] becomes the new shift_d[0].
                        bit_d   = bit_q + BIT_ONE;
                        sdata_d = shift_q[1];
                    end else if (PAR_ON && (bit_q == DATA_LAST)) begin
                        bit_d   = bit_q + BIT_ONE;
                        sdata_d = parity_q;
                    end else begin
                        // The last data bit (or the parity slot) has finished.
                        bit_d   = BIT_ZERO;
                        state_d = ST_STOP;
                        sdata_d = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end

            ST_STOP: begin
                sdata_d = 1'b1;
                if (bit_end_s) begin
                    baud_d = BAUD_ZERO;
                    if (bit_q == STOP_LAST) begin
                        bit_d   = BIT_ZERO;
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        bit_d = bit_q + BIT_ONE;
                    end
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end

            default: begin
                // Recover from an illegal encoding with the line released.
                state_d = ST_IDLE;
                baud_d  = BAUD_ZERO;
                bit_d   = BIT_ZERO;
                sdata_d = 1'b1;
            end
        endcase
    end

    // State, counters, shift register and registered line/done outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            baud_q   <= BAUD_ZERO;
            bit_q    <= BIT_ZERO;
            shift_q  <= {DATA_W{1'b0}};
            parity_q <= 1'b0;
            sdata_q  <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            sdata_q  <= sdata_d;
            done_q   <= done_d;
        end
    end

    assign tx_ready  = (state_q == ST_IDLE);
    assign sdata_out = sdata_q;
    assign tx_done   = done_q;
    assign state     = state_q;

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx. Two instances share one clock and one reset:
//   u_a: CLK_DIV=4, DATA_W=8, no parity, 1 stop bit  (10 slots, F=40)
//   u_b: CLK_DIV=2, DATA_W=8, even parity, 2 stop bits (12 slots, F=24)
// Expected line contents are given per slot, where bit i is the value of slot i.
module tb_serial_tx;

    logic       clk;
    logic       rst;
    logic [7:0] a_data, b_data;
    logic       a_valid, b_valid;
    logic       a_ready, b_ready;
    logic       a_sd, b_sd;
    logic       a_done, b_done;
    logic [1:0] a_state, b_state;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_done_cyc = 0;

    serial_tx #(.CLK_DIV(4), .DATA_W(8), .PARITY_EN(0), .STOP_BITS(1)) u_a (
        .clk(clk), .rst(rst), .tx_data(a_data), .tx_valid(a_valid),
        .tx_ready(a_ready), .sdata_out(a_sd), .tx_done(a_done), .state(a_state)
    );

    serial_tx #(.CLK_DIV(2), .DATA_W(8), .PARITY_EN(1), .STOP_BITS(2)) u_b (
        .clk(clk), .rst(rst), .tx_data(b_data), .tx_valid(b_valid),
        .tx_ready(b_ready), .sdata_out(b_sd), .tx_done(b_done), .state(b_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic        use_b;
        logic [7:0]  data;
        logic [15:0] slots;
    } vec_t;

    vec_t vecs[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic rd(input logic b, output logic sd, output logic rdy,
                      output logic dn, output logic [1:0] st);
        sd  = b ? b_sd    : a_sd;
        rdy = b ? b_ready : a_ready;
        dn  = b ? b_done  : a_done;
        st  = b ? b_state : a_state;
    endtask

    task automatic chk_idle(input logic b, input string nm);
        logic sd, rdy, dn;
        logic [1:0] st;
        rd(b, sd, rdy, dn, st);
        chk({nm, "_line"},  32'(sd),  32'd1);
        chk({nm, "_ready"}, 32'(rdy), 32'd1);
        chk({nm, "_state"}, 32'(st),  32'd0);
        chk({nm, "_done"},  32'(dn),  32'd0);
    endtask

    // Present a word with valid high and step to 1 ns after the accepting edge.
    task automatic send(input logic b, input logic [7:0] d, input logic hold);
        if (b) begin b_data = d; b_valid = 1'b1; end
        else   begin a_data = d; a_valid = 1'b1; end
        tick();
        if (!hold) begin
            if (b) b_valid = 1'b0; else a_valid = 1'b0;
        end
    endtask

    // Called 1 ns after accept edge k. Checks every cycle up to and including k+F.
    task automatic check_frame(input logic b, input logic [15:0] slots,
                               input int change_at, input logic [7:0] new_data);
        int cd, ns, nd, s, exp_st;
        logic sd, rdy, dn;
        logic [1:0] st;
        cd = b ? 2 : 4;
        ns = b ? 12 : 10;
        nd = b ? 9 : 8;     // last slot that is still in DATA (data bits or parity)
        for (int j = 0; j < cd * ns; j++) begin
            s = j / cd;
            if (j == change_at) begin
                if (b) b_data = new_data; else a_data = new_data;
            end
            rd(b, sd, rdy, dn, st);
            exp_st = (s == 0) ? 1 : ((s <= nd) ? 2 : 3);
            chk("frame_line",  32'(sd),  32'(slots[s]));
            chk("frame_state", 32'(st),  32'(exp_st));
            chk("frame_ready", 32'(rdy), 32'd0);
            chk("frame_done",  32'(dn),  32'd0);
            tick();
        end
        rd(b, sd, rdy, dn, st);
        chk("end_state", 32'(st),  32'd0);
        chk("end_ready", 32'(rdy), 32'd1);
        chk("end_done",  32'(dn),  32'd1);
        chk("end_line",  32'(sd),  32'd1);
        last_done_cyc = cyc;
    endtask

    initial begin
        int first_done;
        logic sd, rdy, dn;
        logic [1:0] st;

        // The slot vectors are start(0), data LSB first, [parity], stop(s).
        vecs[0] = '{1'b0, 8'hA5, {6'b0, 1'b1, 8'hA5, 1'b0}};
        vecs[1] = '{1'b0, 8'h00, {6'b0, 1'b1, 8'h00, 1'b0}};
        vecs[2] = '{1'b0, 8'hFF, {6'b0, 1'b1, 8'hFF, 1'b0}};
        vecs[3] = '{1'b0, 8'h5A, {6'b0, 1'b1, 8'h5A, 1'b0}};
        vecs[4] = '{1'b1, 8'h07, {4'b0, 2'b11, 1'b1, 8'h07, 1'b0}};  // 3 ones -> parity 1
        vecs[5] = '{1'b1, 8'h03, {4'b0, 2'b11, 1'b0, 8'h03, 1'b0}};  // 2 ones -> parity 0
        vecs[6] = '{1'b1, 8'h80, {4'b0, 2'b11, 1'b1, 8'h80, 1'b0}};  // 1 one  -> parity 1
        vecs[7] = '{1'b1, 8'hFE, {4'b0, 2'b11, 1'b1, 8'hFE, 1'b0}};  // 7 ones -> parity 1

        rst = 1'b1;
        a_data = 8'h00; b_data = 8'h00;
        a_valid = 1'b0; b_valid = 1'b0;

        // Reset, then an idle line for 20 clocks.
        repeat (3) tick();
        chk_idle(1'b0, "rst_a");
        chk_idle(1'b1, "rst_b");
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk_idle(1'b0, "idle_a");
            chk_idle(1'b1, "idle_b");
        end

        // Single frames from the table, for both the plain and the parity configuration.
        for (int v = 0; v < 8; v++) begin
            send(vecs[v].use_b, vecs[v].data, 1'b0);
            check_frame(vecs[v].use_b, vecs[v].slots, -1, 8'h00);
            tick();
            chk_idle(vecs[v].use_b, "post_frame");
        end

        // Back-to-back: valid held high, 0x00 and then 0xFF.
        send(1'b0, 8'h00, 1'b1);
        check_frame(1'b0, {6'b0, 1'b1, 8'h00, 1'b0}, 0, 8'hFF);
        first_done = last_done_cyc;
        tick();                      // edge k+41 takes the second word
        a_valid = 1'b0;
        check_frame(1'b0, {6'b0, 1'b1, 8'hFF, 1'b0}, -1, 8'h00);
        chk("b2b_done_gap", 32'(last_done_cyc - first_done), 32'd41);
        tick();
        chk_idle(1'b0, "b2b_after");

        // A change to tx_data during the frame is ignored. The changed value is
        // sent next because valid stays high.
        send(1'b0, 8'hA5, 1'b1);
        check_frame(1'b0, {6'b0, 1'b1, 8'hA5, 1'b0}, 10, 8'h3C);
        tick();
        a_valid = 1'b0;
        check_frame(1'b0, {6'b0, 1'b1, 8'h3C, 1'b0}, -1, 8'h00);
        tick();
        chk_idle(1'b0, "hold_after");

        // Asynchronous reset mid-frame, between clock edges.
        send(1'b0, 8'hA5, 1'b0);
        repeat (17) tick();
        rd(1'b0, sd, rdy, dn, st);
        chk("mid_state_before_rst", 32'(st), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        rd(1'b0, sd, rdy, dn, st);
        chk("async_rst_line",  32'(sd),  32'd1);
        chk("async_rst_state", 32'(st),  32'd0);
        chk("async_rst_ready", 32'(rdy), 32'd1);
        a_valid = 1'b1;              // reset must win over valid
        a_data  = 8'h55;
        tick();
        tick();
        chk_idle(1'b0, "rst_vs_valid");
        a_valid = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_idle(1'b0, "post_rst");
        end
        send(1'b0, 8'h81, 1'b0);
        check_frame(1'b0, {6'b0, 1'b1, 8'h81, 1'b0}, -1, 8'h00);
        tick();
        chk_idle(1'b0, "final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_tx.md
Name: serial_tx

Overview:
- Serial transmitter: the stage directly upstream of the serial receiver.
- Accepts a parallel byte over a valid/ready handshake and serializes it onto a single line.
- Frame: one start bit (low), DATA_W data bits LSB first, optional even-parity bit, STOP_BITS stop bits (high).
- Each bit is held for CLK_DIV clocks, so the receiver's divided-clock sampler sees one bit per divided period.

Parameters:
- CLK_DIV, 16: clocks per serial bit; legal range 2..255.
- DATA_W, 8: data bits per frame; legal range 5..8.
- PARITY_EN, 0: 1 inserts an even-parity bit after the data bits.
- STOP_BITS, 1: number of stop bits; legal values 1 or 2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- tx_data  input  DATA_W  byte to send; sampled only on handshake.
- tx_valid  input  1  tx_data valid.
- tx_ready  output  1  block can accept a byte; combinational, equal to (state==IDLE).
- sdata_out  output  1  serial line; registered; idles high.
- tx_done  output  1  one-cycle pulse when the last stop bit completes.
- state  output  2  current FSM state: IDLE=0, START=1, DATA=2, STOP=3.

Behaviour:
- Reset (async, rst=1): takes effect immediately, without waiting for a clock.
  - state=IDLE, sdata_out=1, tx_done=0, baud counter=0, bit counter=0, shift register=0.
  - Reset mid-frame aborts the frame; the line returns high at once.
  - No partial frame resumes after reset release.
- Handshake:
  - Transfer occurs on a rising edge where tx_valid=1 and tx_ready=1.
  - tx_data is latched into the shift register at that edge.
  - tx_data and tx_valid are don't-care at all other times; changes during a frame are ignored.
- Baud counter: width ceil(log2(CLK_DIV)); counts 0..CLK_DIV-1. A bit ends when the counter reaches CLK_DIV-1; the counter then wraps to 0.
- FSM (transitions on rising edge):
  - IDLE: sdata_out=1. On handshake go to START; sdata_out=0 from that edge.
  - START: hold 0 for CLK_DIV clocks, then go to DATA with bit counter=0. sdata_out=shift[0].
  - DATA:
    - At each bit end, the shift register shifts right and the bit counter increments.
    - After DATA_W bits: if PARITY_EN=1, send one more bit equal to the XOR of the latched byte (even parity), then go to STOP; otherwise go to STOP directly.
    - sdata_out=1 on entry to STOP.
  - STOP: hold 1 for STOP_BITS*CLK_DIV clocks. At the final bit end go to IDLE and pulse tx_done for exactly the first IDLE cycle.
  - Illegal state encoding: go to IDLE, sdata_out=1.
- Timing:
  - Frame length F = (1 + DATA_W + PARITY_EN + STOP_BITS) * CLK_DIV clocks, measured from the accept edge to the edge entering IDLE.
  - tx_ready is 0 for F cycles after acceptance.
  - Earliest next accept is edge k+F+1, giving a back-to-back frame period of F+1 clocks. The line stays high for 1 clock of inter-frame idle, which the receiver treats as extra stop time.
- tx_valid held high continuously: one byte is accepted per frame period; no byte is accepted while tx_ready=0.
- tx_valid and rst both high at the same edge: reset wins and nothing is accepted.
- sdata_out must be glitch-free; drive it directly from a flop, not from combinational decode.

Test Plan:
1. Reset with line idle (CLK_DIV=4, DATA_W=8, PARITY_EN=0, STOP_BITS=1): assert rst, then hold tx_valid=0 for 20 clocks -> sdata_out=1, tx_ready=1, state=0, tx_done=0 throughout.
2. Single frame: send 0xA5 accepted at edge k -> sdata_out per 4-clock slot: 0, 1,0,1,0,0,1,0,1, 1.
   - state=3 from k+36.
   - IDLE and tx_done=1 at k+40 only.
   - tx_ready=0 over k..k+39.
3. Back-to-back: tx_valid held high with 0x00 then 0xFF -> second start bit begins at k+41; second frame data slots all 1; exactly two tx_done pulses, 41 clocks apart.
4. Data hold-off: change tx_data to 0x3C at k+10 during the 0xA5 frame -> serial output is still 0xA5; 0x3C is sent only if tx_valid is still high after tx_ready returns.
5. Reset mid-frame: assert rst asynchronously (between edges) at k+17 -> sdata_out=1 and state=0 before the next clock edge. After release, the next accepted byte 0x81 produces a clean full frame.
6. Parity and stop bits (PARITY_EN=1, STOP_BITS=2, CLK_DIV=2): send 0x07 -> parity slot=1; two stop slots; tx_done at k+24. Then send 0x03 -> parity slot=0.
